// File: rtl/day_cycle_controller_if.sv
// Control/status bundle of the time-of-day sequencer: run/speed/set/sleep
// requests in, clock, phase, day counter and event pulses out.
interface day_cycle_controller_if;
  logic        run_en;
  logic [1:0]  speed_sel;
  logic        set_req;
  logic [31:0] set_time;
  logic        sleep_req;
  logic [31:0] time_in_sec;
  logic [1:0]  phase;
  logic [15:0] day_count;
  logic        sec_tick;
  logic        phase_change;
  logic        busy;
  logic        sleep_done;
  logic        sleep_rej;
  logic        set_err;

  modport master (
    output run_en, speed_sel, set_req, set_time, sleep_req,
    input  time_in_sec, phase, day_count, sec_tick, phase_change,
           busy, sleep_done, sleep_rej, set_err
  );

  modport slave (
    input  run_en, speed_sel, set_req, set_time, sleep_req,
    output time_in_sec, phase, day_count, sec_tick, phase_change,
           busy, sleep_done, sleep_rej, set_err
  );
endinterface

// File: rtl/day_cycle_controller.sv
// Game time-of-day sequencer: prescaled seconds counter with run/pause, speed
// multiplier, direct set and sleep fast-forward to dawn; derives phase and day count.
module day_cycle_controller #(
  parameter int CLK_HZ      = 50000000,
  parameter int DAY_LEN     = 1200,
  parameter int DAY_START   = 60,
  parameter int DUSK_START  = 600,
  parameter int NIGHT_START = 720
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  day_cycle_controller_if.slave bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_FFWD = 1'b1
  } state_t;

  localparam logic [31:0] CLK_HZ_W    = 32'(CLK_HZ);
  localparam logic [31:0] DAY_LEN_W   = 32'(DAY_LEN);
  localparam logic [31:0] LAST_SEC    = 32'(DAY_LEN - 1);
  localparam logic [31:0] PHASE_BOUND [3] = '{32'(DAY_START), 32'(DUSK_START), 32'(NIGHT_START)};

  state_t      state_reg, state_next;
  logic [31:0] presc_reg, presc_next;
  logic [31:0] time_reg, time_next;
  logic [1:0]  phase_reg, phase_next;
  logic [15:0] day_reg, day_next;
  logic        busy_reg, busy_next;
  logic        sec_tick_reg, sec_tick_next;
  logic        phase_change_reg, phase_change_next;
  logic        sleep_done_reg, sleep_done_next;
  logic        sleep_rej_reg, sleep_rej_next;
  logic        set_err_reg, set_err_next;

  logic [31:0] limit;
  logic        tick_due;
  logic        wrap;
  logic [31:0] time_inc;
  logic        set_ok;
  logic        sleep_ok;
  logic [2:0]  above;

  // Higher speed shortens the prescaler period; a change applies on the next compare.
  assign limit    = CLK_HZ_W >> bus.speed_sel;
  assign tick_due = (presc_reg >= (limit - 32'd1));
  assign wrap     = (time_reg >= LAST_SEC);
  assign time_inc = wrap ? 32'd0 : time_reg + 32'd1;

  assign set_ok   = bus.set_req && (bus.set_time < DAY_LEN_W);
  assign sleep_ok = bus.sleep_req && !bus.set_req &&
                    (state_reg == ST_RUN) && (phase_reg == 2'd3);

  // Phase is the number of phase boundaries the new time has crossed.
  for (genvar gi = 0; gi < 3; gi++) begin : g_phase_bound
    assign above[gi] = (time_next >= PHASE_BOUND[gi]);
  end

  assign phase_next        = {1'b0, above[0]} + {1'b0, above[1]} + {1'b0, above[2]};
  assign phase_change_next = (phase_next != phase_reg);

  always_comb begin
    state_next      = state_reg;
    presc_next      = presc_reg;
    time_next       = time_reg;
    day_next        = day_reg;
    busy_next       = busy_reg;
    sec_tick_next   = 1'b0;
    sleep_done_next = 1'b0;
    sleep_rej_next  = bus.sleep_req && !sleep_ok;
    set_err_next    = bus.set_req && !set_ok;

    if (set_ok) begin
      // A valid set overrides everything, including an ongoing fast-forward.
      time_next  = bus.set_time;
      presc_next = 32'd0;
      state_next = ST_RUN;
      busy_next  = 1'b0;
    end else if (sleep_ok) begin
      // Acceptance edge only enters FFWD; the pending natural tick is dropped.
      state_next = ST_FFWD;
      busy_next  = 1'b1;
      presc_next = 32'd0;
    end else if (state_reg == ST_FFWD) begin
      presc_next = 32'd0;
      time_next  = time_inc;
      if (wrap) begin
        day_next        = day_reg + 16'd1;
        sleep_done_next = 1'b1;
        busy_next       = 1'b0;
        state_next      = ST_RUN;
      end
    end else if (bus.run_en) begin
      if (tick_due) begin
        presc_next    = 32'd0;
        time_next     = time_inc;
        sec_tick_next = 1'b1;
        if (wrap) begin
          day_next = day_reg + 16'd1;
        end
      end else begin
        presc_next = presc_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg        <= ST_RUN;
      presc_reg        <= 32'd0;
      time_reg         <= 32'd0;
      phase_reg        <= 2'd0;
      day_reg          <= 16'd0;
      busy_reg         <= 1'b0;
      sec_tick_reg     <= 1'b0;
      phase_change_reg <= 1'b0;
      sleep_done_reg   <= 1'b0;
      sleep_rej_reg    <= 1'b0;
      set_err_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      presc_reg        <= presc_next;
      time_reg         <= time_next;
      phase_reg        <= phase_next;
      day_reg          <= day_next;
      busy_reg         <= busy_next;
      sec_tick_reg     <= sec_tick_next;
      phase_change_reg <= phase_change_next;
      sleep_done_reg   <= sleep_done_next;
      sleep_rej_reg    <= sleep_rej_next;
      set_err_reg      <= set_err_next;
    end
  end

  assign bus.time_in_sec  = time_reg;
  assign bus.phase        = phase_reg;
  assign bus.day_count    = day_reg;
  assign bus.sec_tick     = sec_tick_reg;
  assign bus.phase_change = phase_change_reg;
  assign bus.busy         = busy_reg;
  assign bus.sleep_done   = sleep_done_reg;
  assign bus.sleep_rej    = sleep_rej_reg;
  assign bus.set_err      = set_err_reg;

endmodule

// File: tb/tb_day_cycle_controller.sv
// Directed bench for day_cycle_controller with an 8-cycle second and a 20-second day.
module tb_day_cycle_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  day_cycle_controller_if bus ();

  day_cycle_controller #(
    .CLK_HZ(8), .DAY_LEN(20), .DAY_START(2), .DUSK_START(10), .NIGHT_START(14)
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 64 && cycles < 0; i++) begin
      step();
      if (bus.sec_tick === 1'b1) cycles = i;
    end
  endtask

  task automatic pulse_set(input logic [31:0] t);
    bus.set_req  = 1'b1;
    bus.set_time = t;
    step();
    bus.set_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++; if (bus.time_in_sec !== 32'd0) begin n_fail++; $display("FAIL reset_time: got %0d expected 0", bus.time_in_sec); end
    n_checks++; if ({bus.phase, bus.day_count} !== 18'd0) begin n_fail++; $display("FAIL reset_phase_day: got phase %0d day %0d expected 0 0", bus.phase, bus.day_count); end
    n_checks++; if ({bus.sec_tick, bus.phase_change, bus.sleep_done, bus.sleep_rej, bus.set_err, bus.busy} !== 6'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {bus.sec_tick, bus.phase_change, bus.sleep_done, bus.sleep_rej, bus.set_err, bus.busy}); end
    rst_n      = 1'b1;
    bus.run_en = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_natural();
    int c;
    int bad;
    wait_tick(c);
    n_checks++; if (c !== 8) begin n_fail++; $display("FAIL first_tick_latency: got %0d expected 8", c); end
    n_checks++; if (bus.time_in_sec !== 32'd1) begin n_fail++; $display("FAIL first_tick_time: got %0d expected 1", bus.time_in_sec); end
    wait_tick(c);
    n_checks++; if ({bus.time_in_sec, bus.phase, bus.phase_change} !== {32'd2, 2'd1, 1'b1}) begin n_fail++; $display("FAIL dawn_to_day: got time %0d phase %0d pc %0d expected 2 1 1", bus.time_in_sec, bus.phase, bus.phase_change); end
    bad = 0;
    for (int k = 3; k <= 20; k++) begin
      wait_tick(c);
      if (c != 8) bad++;
      if (k == 3 && bus.phase_change !== 1'b0) bad++;
      if (k == 14 && bus.phase !== 2'd3) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL tick_period: got %0d bad ticks expected 0", bad); end
    n_checks++; if ({bus.time_in_sec, bus.day_count, bus.phase, bus.phase_change} !== {32'd0, 16'd1, 2'd0, 1'b1}) begin n_fail++; $display("FAIL day_wrap: got time %0d day %0d phase %0d pc %0d expected 0 1 0 1", bus.time_in_sec, bus.day_count, bus.phase, bus.phase_change); end
    $display("test_natural: done, time %0d day %0d", bus.time_in_sec, bus.day_count);
  endtask

  task automatic test_speed();
    int c;
    int ticks;
    bus.speed_sel = 2'd3;
    wait_tick(c);
    n_checks++; if (c !== 1) begin n_fail++; $display("FAIL speed3_period: got %0d expected 1", c); end
    bus.speed_sel = 2'd2;
    wait_tick(c);
    n_checks++; if (c !== 2) begin n_fail++; $display("FAIL speed2_period: got %0d expected 2", c); end
    bus.speed_sel = 2'd0;
    ticks = 0;
    repeat (3) begin step(); if (bus.sec_tick === 1'b1) ticks++; end
    bus.speed_sel = 2'd3;
    step();
    n_checks++; if ({ticks[3:0], bus.sec_tick, bus.time_in_sec} !== {4'd0, 1'b1, 32'd3}) begin n_fail++; $display("FAIL speed_switch: got early %0d tick %0d time %0d expected 0 1 3", ticks, bus.sec_tick, bus.time_in_sec); end
    bus.speed_sel = 2'd0;
    $display("test_speed: done, time %0d", bus.time_in_sec);
  endtask

  task automatic test_pause();
    int c;
    int ticks;
    ticks = 0;
    repeat (5) begin step(); if (bus.sec_tick === 1'b1) ticks++; end
    bus.run_en = 1'b0;
    repeat (30) begin step(); if (bus.sec_tick === 1'b1) ticks++; end
    n_checks++; if ({ticks[3:0], bus.time_in_sec} !== {4'd0, 32'd3}) begin n_fail++; $display("FAIL pause_hold: got ticks %0d time %0d expected 0 3", ticks, bus.time_in_sec); end
    bus.run_en = 1'b1;
    wait_tick(c);
    n_checks++; if (c !== 3) begin n_fail++; $display("FAIL resume_latency: got %0d expected 3", c); end
    n_checks++; if (bus.time_in_sec !== 32'd4) begin n_fail++; $display("FAIL resume_time: got %0d expected 4", bus.time_in_sec); end
    bus.run_en = 1'b0;
    $display("test_pause: done, time %0d", bus.time_in_sec);
  endtask

  task automatic test_set();
    pulse_set(32'd15);
    n_checks++; if ({bus.time_in_sec, bus.phase, bus.phase_change, bus.set_err} !== {32'd15, 2'd3, 1'b1, 1'b0}) begin n_fail++; $display("FAIL set_valid: got time %0d phase %0d pc %0d err %0d expected 15 3 1 0", bus.time_in_sec, bus.phase, bus.phase_change, bus.set_err); end
    n_checks++; if (bus.day_count !== 16'd1) begin n_fail++; $display("FAIL set_keeps_day: got %0d expected 1", bus.day_count); end
    pulse_set(32'd20);
    n_checks++; if ({bus.set_err, bus.time_in_sec, bus.phase_change} !== {1'b1, 32'd15, 1'b0}) begin n_fail++; $display("FAIL set_out_of_range: got err %0d time %0d pc %0d expected 1 15 0", bus.set_err, bus.time_in_sec, bus.phase_change); end
    step();
    n_checks++; if (bus.set_err !== 1'b0) begin n_fail++; $display("FAIL set_err_pulse: got %0d expected 0", bus.set_err); end
    $display("test_set: done, time %0d", bus.time_in_sec);
  endtask

  task automatic test_sleep();
    int bad;
    bus.sleep_req = 1'b1;
    step();
    bus.sleep_req = 1'b0;
    n_checks++; if ({bus.busy, bus.sleep_rej, bus.time_in_sec} !== {1'b1, 1'b0, 32'd15}) begin n_fail++; $display("FAIL sleep_accept: got busy %0d rej %0d time %0d expected 1 0 15", bus.busy, bus.sleep_rej, bus.time_in_sec); end
    bad = 0;
    for (int k = 16; k <= 19; k++) begin
      step();
      if (bus.time_in_sec !== 32'(k) || bus.busy !== 1'b1 || bus.sleep_done !== 1'b0 || bus.sec_tick !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ffwd_steps: got %0d bad cycles expected 0", bad); end
    step();
    n_checks++; if ({bus.time_in_sec, bus.day_count, bus.phase, bus.phase_change} !== {32'd0, 16'd2, 2'd0, 1'b1}) begin n_fail++; $display("FAIL ffwd_wrap: got time %0d day %0d phase %0d pc %0d expected 0 2 0 1", bus.time_in_sec, bus.day_count, bus.phase, bus.phase_change); end
    n_checks++; if ({bus.sleep_done, bus.busy} !== 2'b10) begin n_fail++; $display("FAIL ffwd_done: got done %0d busy %0d expected 1 0", bus.sleep_done, bus.busy); end
    step();
    n_checks++; if ({bus.sleep_done, bus.time_in_sec} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL sleep_done_pulse: got done %0d time %0d expected 0 0", bus.sleep_done, bus.time_in_sec); end
    pulse_set(32'd5);
    bus.sleep_req = 1'b1;
    step();
    bus.sleep_req = 1'b0;
    n_checks++; if ({bus.sleep_rej, bus.busy, bus.time_in_sec} !== {1'b1, 1'b0, 32'd5}) begin n_fail++; $display("FAIL sleep_reject_day: got rej %0d busy %0d time %0d expected 1 0 5", bus.sleep_rej, bus.busy, bus.time_in_sec); end
    bus.sleep_req = 1'b1;
    pulse_set(32'd15);
    bus.sleep_req = 1'b0;
    n_checks++; if ({bus.sleep_rej, bus.busy, bus.time_in_sec} !== {1'b1, 1'b0, 32'd15}) begin n_fail++; $display("FAIL sleep_vs_set: got rej %0d busy %0d time %0d expected 1 0 15", bus.sleep_rej, bus.busy, bus.time_in_sec); end
    $display("test_sleep: done, time %0d day %0d", bus.time_in_sec, bus.day_count);
  endtask

  task automatic test_ffwd_abort();
    int bad;
    bus.sleep_req = 1'b1;
    step();
    bus.sleep_req = 1'b0;
    pulse_set(32'd25);
    n_checks++; if ({bus.set_err, bus.time_in_sec, bus.busy} !== {1'b1, 32'd16, 1'b1}) begin n_fail++; $display("FAIL bad_set_in_ffwd: got err %0d time %0d busy %0d expected 1 16 1", bus.set_err, bus.time_in_sec, bus.busy); end
    step();
    pulse_set(32'd3);
    n_checks++; if ({bus.time_in_sec, bus.busy, bus.sleep_done, bus.phase} !== {32'd3, 1'b0, 1'b0, 2'd1}) begin n_fail++; $display("FAIL ffwd_abort: got time %0d busy %0d done %0d phase %0d expected 3 0 0 1", bus.time_in_sec, bus.busy, bus.sleep_done, bus.phase); end
    bad = 0;
    repeat (3) begin
      step();
      if (bus.sleep_done !== 1'b0 || bus.time_in_sec !== 32'd3 || bus.busy !== 1'b0) bad++;
    end
    n_checks++; if ({bad[3:0], bus.day_count} !== {4'd0, 16'd2}) begin n_fail++; $display("FAIL after_abort: got bad %0d day %0d expected 0 2", bad, bus.day_count); end
    $display("test_ffwd_abort: done, time %0d", bus.time_in_sec);
  endtask

  task automatic test_reset_mid_ffwd();
    pulse_set(32'd15);
    bus.sleep_req = 1'b1;
    step();
    bus.sleep_req = 1'b0;
    step();
    step();
    n_checks++; if ({bus.busy, bus.time_in_sec} !== {1'b1, 32'd17}) begin n_fail++; $display("FAIL pre_reset_ffwd: got busy %0d time %0d expected 1 17", bus.busy, bus.time_in_sec); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.time_in_sec, bus.day_count, bus.phase} !== 50'd0) begin n_fail++; $display("FAIL async_reset_values: got time %0d day %0d phase %0d expected 0 0 0", bus.time_in_sec, bus.day_count, bus.phase); end
    n_checks++; if ({bus.sec_tick, bus.phase_change, bus.sleep_done, bus.sleep_rej, bus.set_err, bus.busy} !== 6'd0) begin n_fail++; $display("FAIL async_reset_flags: got %b expected 000000", {bus.sec_tick, bus.phase_change, bus.sleep_done, bus.sleep_rej, bus.set_err, bus.busy}); end
    step();
    rst_n = 1'b1;
    repeat (3) step();
    n_checks++; if ({bus.time_in_sec, bus.busy, bus.sleep_done} !== {32'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL post_reset_idle: got time %0d busy %0d done %0d expected 0 0 0", bus.time_in_sec, bus.busy, bus.sleep_done); end
    $display("test_reset_mid_ffwd: done");
  endtask

  initial begin
    bus.run_en    = 1'b0;
    bus.speed_sel = 2'd0;
    bus.set_req   = 1'b0;
    bus.set_time  = 32'd0;
    bus.sleep_req = 1'b0;
    test_reset();
    test_natural();
    test_speed();
    test_pause();
    test_set();
    test_sleep();
    test_ffwd_abort();
    test_reset_mid_ffwd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
